// File: rtl/text_pkg.sv
// Shared constants, state encoding and address helper for the text buffer writer.
package text_pkg;

  localparam int COLS  = 32'd80;
  localparam int ROWS  = 32'd8;
  localparam int CELLS = 32'd640;

  localparam logic [6:0] LAST_COL = 7'd79;
  localparam logic [2:0] LAST_ROW = 3'd7;
  localparam logic [9:0] CELLS_N  = 10'd640;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_NL = 8'h0D;
  localparam logic [7:0] CH_FF = 8'h0C;

  localparam logic [4:0] G_SPACE = 5'd0;
  localparam logic [4:0] G_A     = 5'd1;
  localparam logic [4:0] G_STAR  = 5'd27;
  localparam logic [4:0] G_HASH  = 5'd28;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // row*80 + col built from shifts: 80 = 64 + 16
  function automatic logic [9:0] cell_addr(input logic [2:0] row, input logic [6:0] col);
    return ({7'd0, row} << 4'd6) + ({7'd0, row} << 4'd4) + {3'd0, col};
  endfunction

endpackage

// File: rtl/text_buffer_writer_if.sv
// Byte-in handshake plus character RAM write port of the text buffer writer.
interface text_buffer_writer_if;

  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic [9:0] wr_addr;
  logic [4:0] wr_data;
  logic       wr_en;

  modport master (
    output in_valid, in_char,
    input  in_ready, wr_addr, wr_data, wr_en
  );

  modport slave (
    input  in_valid, in_char,
    output in_ready, wr_addr, wr_data, wr_en
  );

endinterface

// File: rtl/text_buffer_writer_glyph.sv
// ascii_to_glyph: combinational ASCII byte to 5-bit glyph code decoder.
module ascii_to_glyph
  import text_pkg::*;
(
  input  logic [7:0] in_char,
  output logic [4:0] glyph,
  output logic       is_printable,
  output logic       is_ctrl,
  output logic       has_glyph
);

  logic [7:0] upper_ofs_s;
  logic [7:0] lower_ofs_s;

  assign upper_ofs_s = in_char - 8'h40;
  assign lower_ofs_s = in_char - 8'h60;

  // Letter/symbol mapping; printable bytes without a glyph report has_glyph=0
  always_comb begin
    glyph     = G_SPACE;
    has_glyph = 1'b0;
    if (in_char >= 8'h41 && in_char <= 8'h5A) begin
      glyph     = upper_ofs_s[4:0];
      has_glyph = 1'b1;
    end else if (in_char >= 8'h61 && in_char <= 8'h7A) begin
      glyph     = lower_ofs_s[4:0];
      has_glyph = 1'b1;
    end else if (in_char == 8'h2A) begin
      glyph     = G_STAR;
      has_glyph = 1'b1;
    end else if (in_char == 8'h23) begin
      glyph     = G_HASH;
      has_glyph = 1'b1;
    end else if (in_char == 8'h20) begin
      glyph     = G_SPACE;
      has_glyph = 1'b1;
    end else begin
      glyph     = G_SPACE;
      has_glyph = 1'b0;
    end
  end

  assign is_printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign is_ctrl      = (in_char == CH_BS) || (in_char == CH_NL) || (in_char == CH_FF);

endmodule

// File: rtl/text_buffer_writer.sv
// Cursor-driven writer for the 80x8 text RAM; clears the RAM after reset and on form feed.
// Define TEXT_WRAP_EN to wrap at the end of the buffer instead of saturating.
module text_buffer_writer
  import text_pkg::*;
#(
  parameter logic [4:0] CLEAR_CODE = G_SPACE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  text_buffer_writer_if.slave  bus,
  output logic [6:0]           cursor_col,
  output logic [2:0]           cursor_row,
  output logic                 busy,
  output logic                 overflow
);

  state_t     state_r, state_n;
  logic [9:0] cnt_r, cnt_n;
  logic [6:0] col_r, col_n;
  logic [2:0] row_r, row_n;
  logic       at_end_r, at_end_n;
  logic       ovf_r, ovf_n;
  logic       wr_en_r, wr_en_n;
  logic [9:0] wr_addr_r, wr_addr_n;
  logic [4:0] wr_data_r, wr_data_n;
  logic       busy_r, busy_n;
  logic       ready_r, ready_n;

  logic [4:0] glyph_s;
  logic       is_printable_s, is_ctrl_s, has_glyph_s;
  logic       accept_s, last_col_s, last_row_s;
  logic [9:0] cur_addr_s;

  ascii_to_glyph u_glyph (
    .in_char      (bus.in_char),
    .glyph        (glyph_s),
    .is_printable (is_printable_s),
    .is_ctrl      (is_ctrl_s),
    .has_glyph    (has_glyph_s)
  );

  assign accept_s   = bus.in_valid & ready_r;
  assign last_col_s = (col_r == LAST_COL);
  assign last_row_s = (row_r == LAST_ROW);
  assign cur_addr_s = cell_addr(row_r, col_r);

  // Next-state and next-output decode; outputs are registered alongside the state
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    col_n     = col_r;
    row_n     = row_r;
    at_end_n  = at_end_r;
    ovf_n     = ovf_r;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_r;
    wr_data_n = wr_data_r;
    busy_n    = busy_r;
    ready_n   = 1'b0;
    case (state_r)
      CLEAR: begin
        if (cnt_r < CELLS_N) begin
          wr_en_n   = 1'b1;
          wr_addr_n = cnt_r;
          wr_data_n = CLEAR_CODE;
          cnt_n     = cnt_r + 10'd1;
          busy_n    = 1'b1;
        end else begin
          state_n  = IDLE;
          cnt_n    = 10'd0;
          col_n    = 7'd0;
          row_n    = 3'd0;
          at_end_n = 1'b0;
          busy_n   = 1'b0;
          ready_n  = 1'b1;
        end
      end
      IDLE: begin
        ready_n = 1'b1;
        if (accept_s) begin
          ready_n = 1'b0;
          state_n = WRITE;
          if (is_ctrl_s) begin
            case (bus.in_char)
              CH_FF: begin
                state_n  = CLEAR;
                cnt_n    = 10'd0;
                col_n    = 7'd0;
                row_n    = 3'd0;
                at_end_n = 1'b0;
                ovf_n    = 1'b0;
                busy_n   = 1'b1;
              end
              CH_NL: begin
                col_n    = 7'd0;
                at_end_n = 1'b0;
`ifdef TEXT_WRAP_EN
                row_n = last_row_s ? 3'd0 : row_r + 3'd1;
`else
                row_n = last_row_s ? row_r : row_r + 3'd1;
`endif
              end
              CH_BS: begin
                wr_data_n = CLEAR_CODE;
                // With the end flag set the cursor sits logically past (7,79): erase that cell in place
                if (at_end_r) begin
                  at_end_n  = 1'b0;
                  wr_en_n   = 1'b1;
                  wr_addr_n = cur_addr_s;
                end else if (col_r != 7'd0) begin
                  col_n     = col_r - 7'd1;
                  wr_en_n   = 1'b1;
                  wr_addr_n = cell_addr(row_r, col_r - 7'd1);
                end else if (row_r != 3'd0) begin
                  row_n     = row_r - 3'd1;
                  col_n     = LAST_COL;
                  wr_en_n   = 1'b1;
                  wr_addr_n = cell_addr(row_r - 3'd1, LAST_COL);
                end else begin
                  wr_en_n = 1'b0;
                end
              end
              default: begin
                state_n = WRITE;
              end
            endcase
          end else if (is_printable_s && has_glyph_s) begin
`ifdef TEXT_WRAP_EN
            wr_en_n   = 1'b1;
            wr_addr_n = cur_addr_s;
            wr_data_n = glyph_s;
            col_n     = last_col_s ? 7'd0 : col_r + 7'd1;
            row_n     = last_col_s ? (last_row_s ? 3'd0 : row_r + 3'd1) : row_r;
`else
            if (at_end_r) begin
              ovf_n = 1'b1;
            end else begin
              wr_en_n   = 1'b1;
              wr_addr_n = cur_addr_s;
              wr_data_n = glyph_s;
              if (last_col_s && last_row_s) begin
                at_end_n = 1'b1;
              end else begin
                col_n = last_col_s ? 7'd0 : col_r + 7'd1;
                row_n = last_col_s ? row_r + 3'd1 : row_r;
              end
            end
`endif
          end else begin
            state_n = WRITE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WRITE: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
      default: begin
        state_n = CLEAR;
        cnt_n   = 10'd0;
        busy_n  = 1'b1;
      end
    endcase
  end

  // State, cursor and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= CLEAR;
      cnt_r     <= 10'd0;
      col_r     <= 7'd0;
      row_r     <= 3'd0;
      at_end_r  <= 1'b0;
      ovf_r     <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 10'd0;
      wr_data_r <= CLEAR_CODE;
      busy_r    <= 1'b1;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      col_r     <= col_n;
      row_r     <= row_n;
      at_end_r  <= at_end_n;
      ovf_r     <= ovf_n;
      wr_en_r   <= wr_en_n;
      wr_addr_r <= wr_addr_n;
      wr_data_r <= wr_data_n;
      busy_r    <= busy_n;
      ready_r   <= ready_n;
    end
  end

  assign bus.in_ready = ready_r;
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign cursor_col   = col_r;
  assign cursor_row   = row_r;
  assign busy         = busy_r;
  assign overflow     = ovf_r;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer; RAM writes are checked against a scoreboard queue.
module tb_text_buffer_writer;

  logic       clk;
  logic       rst_n;
  logic [6:0] cursor_col;
  logic [2:0] cursor_row;
  logic       busy;
  logic       overflow;

  int n_checks;
  int n_pass;
  int wr_count;
  logic [14:0] exp_q[$];

  text_buffer_writer_if bus ();

  text_buffer_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Every RAM write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {17'd0, bus.wr_addr, bus.wr_data}, 32'hFFFF_FFFF);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        check("wr_cell", {17'd0, bus.wr_addr, bus.wr_data}, {17'd0, e});
      end
    end
  end

  task automatic push(input int addr, input logic [4:0] data);
    logic [9:0] a;
    a = addr[9:0];
    exp_q.push_back({a, data});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic send(input logic [7:0] c, input logic exp_wr);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    @(negedge clk);
    check("wr_latency", {31'd0, bus.wr_en}, {31'd0, exp_wr});
  endtask

  task automatic check_cursor(input string tag, input int row, input int col);
    check(tag, {22'd0, cursor_row, cursor_col}, {22'd0, row[2:0], col[6:0]});
  endtask

  task automatic check_reset(input string tag);
    check(tag, {10'd0, busy, bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, cursor_row, cursor_col, overflow},
               {10'd0, 1'b1, 1'b0, 1'b0, 10'd0, 5'd0, 3'd0, 7'd0, 1'b0});
  endtask

  initial begin
    int base;
    int n;
    n_checks     = 0;
    n_pass       = 0;
    wr_count     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;

    repeat (3) @(negedge clk);
    check_reset("reset_state");

    // Power-up clear sweep
    for (int i = 0; i < 640; i++) push(i, 5'd0);
    base  = wr_count;
    rst_n = 1'b1;
    wait_idle(700);
    check("clear_count", wr_count - base, 32'd640);
    check("clear_queue", exp_q.size(), 32'd0);
    check("busy_after_clear", {31'd0, busy}, 32'd0);
    check_cursor("cursor_after_clear", 0, 0);

    // "Hi"
    push(0, 5'd8);
    send(8'h48, 1'b1);
    push(1, 5'd9);
    send(8'h69, 1'b1);
    wait_idle(5);
    check_cursor("cursor_hi", 0, 2);

    // Advance to (0,5), newline, then 'A'
    push(2, 5'd1);  send(8'h61, 1'b1);
    push(3, 5'd2);  send(8'h62, 1'b1);
    push(4, 5'd3);  send(8'h63, 1'b1);
    wait_idle(5);
    check_cursor("cursor_05", 0, 5);
    send(8'h0D, 1'b0);
    push(80, 5'd1);
    send(8'h41, 1'b1);
    wait_idle(5);
    check_cursor("cursor_nl_a", 1, 1);

    // Discarded bytes: printable without glyph and unhandled control
    send(8'h31, 1'b0);
    send(8'h00, 1'b0);
    wait_idle(5);
    check_cursor("cursor_discard", 1, 1);

    // Backspace across the row boundary and down to (0,0)
    push(80, 5'd0);
    send(8'h08, 1'b1);
    wait_idle(5);
    check_cursor("cursor_bs_10", 1, 0);
    push(79, 5'd0);
    send(8'h08, 1'b1);
    wait_idle(5);
    check_cursor("cursor_bs_079", 0, 79);
    for (int i = 78; i >= 0; i--) begin
      push(i, 5'd0);
      send(8'h08, 1'b1);
    end
    send(8'h08, 1'b0);
    wait_idle(5);
    check_cursor("cursor_bs_00", 0, 0);

    // Fill the whole buffer with 'Z'
    for (int i = 0; i < 640; i++) begin
      push(i, 5'd26);
      send(8'h5A, 1'b1);
    end
    wait_idle(5);
    check("fill_queue", exp_q.size(), 32'd0);
`ifdef TEXT_WRAP_EN
    check_cursor("cursor_full_wrap", 0, 0);
    push(0, 5'd28);
    send(8'h23, 1'b1);
    wait_idle(5);
    check("overflow_wrap", {31'd0, overflow}, 32'd0);
    check_cursor("cursor_hash_wrap", 0, 1);
`else
    check_cursor("cursor_full", 7, 79);
    check("overflow_before", {31'd0, overflow}, 32'd0);
    send(8'h23, 1'b0);
    wait_idle(5);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    check_cursor("cursor_sat", 7, 79);
    send(8'h0D, 1'b0);
    wait_idle(5);
    check_cursor("cursor_nl_row7", 7, 0);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
`endif

    // Form feed, then reset after 300 sweep writes
    base = wr_count;
    send(8'h0C, 1'b0);
    check("ff_busy_ovf", {30'd0, busy, overflow}, {30'd0, 1'b1, 1'b0});
    check_cursor("cursor_ff", 0, 0);
    for (int i = 0; i < 300; i++) push(i, 5'd0);
    n = 0;
    while ((wr_count - base) < 300 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("sweep_300", wr_count - base, 32'd300);
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid_sweep");
    @(negedge clk);
    check_reset("reset_held");
    for (int i = 0; i < 640; i++) push(i, 5'd0);
    base  = wr_count;
    rst_n = 1'b1;
    wait_idle(700);
    check("resweep_count", wr_count - base, 32'd640);
    check("resweep_queue", exp_q.size(), 32'd0);
    check_cursor("cursor_resweep", 0, 0);

    push(0, 5'd2);
    send(8'h42, 1'b1);
    wait_idle(5);
    check_cursor("cursor_final", 0, 1);
    check("final_queue", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
